// File: rtl/exception_redirect_ctrl.sv
// exception_redirect_ctrl
// Front-end PC redirect arbiter and exception controller. Picks one redirect
// per cycle from branch-miss recovery, registered exception requests,
// exception return and jumps. It also keeps the privilege mode, the saved
// context (EPC, cause, saved mode) and a RUN/HANDLER/DFAULT state machine.
//
// Redirect interface: o_redirect is a single-cycle, combinational valid
// qualifying o_redirect_pc and o_store_current. There is no ready: fetch
// must accept a redirect in the cycle it is presented. When o_redirect is
// low, o_redirect_pc and o_store_current are driven to zero.
module exception_redirect_ctrl #(
  parameter int              PC_W           = 16,
  parameter int              NUM_EXC        = 4,
  parameter logic [PC_W-1:0] HANDLER_BASE   = 16'h0000,
  parameter logic [PC_W-1:0] HANDLER_STRIDE = 16'h0100,
  parameter logic [PC_W-1:0] DFAULT_PC      = 16'hFF00,
  localparam int             CW             = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_miss,
  input  logic [PC_W-1:0]    i_branch_pc,
  input  logic               i_jump,
  input  logic [PC_W-1:0]    i_new_pc,
  input  logic [PC_W-1:0]    i_cur_pc,
  input  logic [NUM_EXC-1:0] i_exc_in,
  input  logic [NUM_EXC-1:0] i_exc_mask,
  input  logic               i_eret,
  input  logic [1:0]         i_mode_set,
  output logic               o_redirect,
  output logic [PC_W-1:0]    o_redirect_pc,
  output logic               o_store_current,
  output logic [1:0]         o_mode,
  output logic [PC_W-1:0]    o_epc,
  output logic [CW-1:0]      o_cause,
  output logic               o_in_handler,
  output logic               o_double_fault,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_DFAULT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_mode;
  logic [1:0]         r_saved_mode;
  logic [PC_W-1:0]    r_epc;
  logic [CW-1:0]      r_cause;
  logic [NUM_EXC-1:0] r_pend;
  logic               r_double_fault;

  state_t             w_state_nxt;
  logic [1:0]         w_mode_nxt;
  logic [1:0]         w_saved_mode_nxt;
  logic [PC_W-1:0]    w_epc_nxt;
  logic [CW-1:0]      w_cause_nxt;
  logic               w_double_fault_nxt;
  logic [NUM_EXC-1:0] w_exc_live;
  logic               w_exc_live_any;
  logic               w_pend_any;
  logic [CW-1:0]      w_pend_idx;
  logic [PC_W-1:0]    w_handler_pc;
  logic               w_eret_ok;

  // Masked sources are invisible: they neither pend nor touch the mode.
  assign w_exc_live     = i_exc_in & ~i_exc_mask;
  assign w_exc_live_any = |w_exc_live;
  assign w_pend_any     = |r_pend;
  assign w_eret_ok      = i_eret && (r_state == ST_HANDLER);
  assign w_handler_pc   = HANDLER_BASE + PC_W'(w_pend_idx) * HANDLER_STRIDE;

  // Lowest-numbered pending source wins (scan high to low, last hit sticks).
  always_comb begin
    w_pend_idx = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (r_pend[i]) w_pend_idx = CW'(i);
    end
  end

  // Redirect arbitration and next-state / next-context selection.
  always_comb begin
    o_redirect         = 1'b0;
    o_redirect_pc      = '0;
    o_store_current    = 1'b0;
    w_state_nxt        = r_state;
    w_epc_nxt          = r_epc;
    w_cause_nxt        = r_cause;
    w_saved_mode_nxt   = r_saved_mode;
    w_double_fault_nxt = r_double_fault;
    if (i_miss) begin
      // Recovery wins outright; a pending exception is simply dropped.
      o_redirect    = 1'b1;
      o_redirect_pc = i_branch_pc;
    end else if (w_pend_any) begin
      o_redirect      = 1'b1;
      o_store_current = 1'b1;
      if (r_state == ST_RUN) begin
        o_redirect_pc    = w_handler_pc;
        w_state_nxt      = ST_HANDLER;
        w_epc_nxt        = i_cur_pc;
        w_cause_nxt      = w_pend_idx;
        w_saved_mode_nxt = r_mode;
      end else begin
        // Fault while already handling: keep the original context intact.
        o_redirect_pc      = DFAULT_PC;
        w_double_fault_nxt = 1'b1;
        w_state_nxt        = ST_DFAULT;
      end
    end else if (w_eret_ok) begin
      o_redirect    = 1'b1;
      o_redirect_pc = r_epc;
      w_state_nxt   = ST_RUN;
    end else if (i_jump) begin
      o_redirect    = 1'b1;
      o_redirect_pc = i_new_pc;
    end
  end

  // Privilege mode: a live exception outranks eret restore, which outranks mode_set.
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_exc_live_any) begin
      w_mode_nxt = {1'b1, r_mode[0]};
    end else if (w_eret_ok) begin
      w_mode_nxt = r_saved_mode;
    end else begin
      case (i_mode_set)
        2'b01:   w_mode_nxt = 2'b00;
        2'b10:   w_mode_nxt = 2'b01;
        2'b11:   w_mode_nxt = {1'b0, r_mode[0]};
        default: w_mode_nxt = r_mode;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Context, mode and exception-sampling registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode         <= 2'b11;
      r_saved_mode   <= 2'b11;
      r_epc          <= '0;
      r_cause        <= '0;
      r_pend         <= '0;
      r_double_fault <= 1'b0;
    end else begin
      r_mode         <= w_mode_nxt;
      r_saved_mode   <= w_saved_mode_nxt;
      r_epc          <= w_epc_nxt;
      r_cause        <= w_cause_nxt;
      r_pend         <= w_exc_live;
      r_double_fault <= w_double_fault_nxt;
    end
  end

  assign o_mode         = r_mode;
  assign o_epc          = r_epc;
  assign o_cause        = r_cause;
  assign o_in_handler   = (r_state != ST_RUN);
  assign o_double_fault = r_double_fault;
  assign o_state        = r_state;

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// tb_exception_redirect_ctrl
// Per-cycle vector table for exception_redirect_ctrl. Each record gives the
// inputs for one clock cycle and the outputs expected during that cycle.
// Expected values go into a queue when inputs are driven and are popped at
// the falling edge. A short hand sequence covers asynchronous reset in the
// middle of a handler.
module tb_exception_redirect_ctrl;

  localparam int EW = 42;

  logic        clk;
  logic        rst;
  logic        miss;
  logic [15:0] branch_pc;
  logic        jump;
  logic [15:0] new_pc;
  logic [15:0] cur_pc;
  logic [3:0]  exc_in;
  logic [3:0]  exc_mask;
  logic        eret;
  logic [1:0]  mode_set;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        store_current;
  logic [1:0]  mode;
  logic [15:0] epc;
  logic [1:0]  cause;
  logic        in_handler;
  logic        double_fault;
  logic [1:0]  state;

  exception_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_miss          (miss),
    .i_branch_pc     (branch_pc),
    .i_jump          (jump),
    .i_new_pc        (new_pc),
    .i_cur_pc        (cur_pc),
    .i_exc_in        (exc_in),
    .i_exc_mask      (exc_mask),
    .i_eret          (eret),
    .i_mode_set      (mode_set),
    .o_redirect      (redirect),
    .o_redirect_pc   (redirect_pc),
    .o_store_current (store_current),
    .o_mode          (mode),
    .o_epc           (epc),
    .o_cause         (cause),
    .o_in_handler    (in_handler),
    .o_double_fault  (double_fault),
    .o_state         (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        miss;
    logic        jump;
    logic        eret;
    logic [3:0]  exc;
    logic [3:0]  mask;
    logic [1:0]  mset;
    logic [15:0] cur;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;

  localparam logic [1:0] S_R = 2'd0;
  localparam logic [1:0] S_H = 2'd1;
  localparam logic [1:0] S_D = 2'd2;

  // Expected-output record; in_handler is derived from the expected state.
  function automatic logic [EW-1:0] pk(input logic red, input logic [15:0] pc,
                                       input logic st, input logic [1:0] md,
                                       input logic [15:0] ep, input logic [1:0] ca,
                                       input logic [1:0] es, input logic df);
    return {red, pc, st, md, ep, ca, (es != 2'd0), es, df};
  endfunction

  function automatic void add(input string n, input logic r, input logic m,
                              input logic j, input logic e, input logic [3:0] x,
                              input logic [3:0] k, input logic [1:0] ms,
                              input logic [15:0] c, input logic [EW-1:0] ex);
    vec_t v;
    v.name = n; v.rst = r; v.miss = m; v.jump = j; v.eret = e;
    v.exc = x; v.mask = k; v.mset = ms; v.cur = c; v.exp = ex;
    vecs.push_back(v);
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    rst      = v.rst;
    miss     = v.miss;
    jump     = v.jump;
    eret     = v.eret;
    exc_in   = v.exc;
    exc_mask = v.mask;
    mode_set = v.mset;
    cur_pc   = v.cur;
  endtask

  task automatic idle_inputs();
    miss = 1'b0; jump = 1'b0; eret = 1'b0;
    exc_in = 4'h0; exc_mask = 4'h0; mode_set = 2'b00;
  endtask

  // Scoreboard compare: pop one expectation and check the live outputs.
  task automatic check(input string name);
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    act = {redirect, redirect_pc, store_current, mode, epc, cause,
           in_handler, state, double_fault};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expectation queued, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got red=%b pc=%h st=%b mode=%b epc=%h cause=%0d inh=%b state=%0d df=%b, expected %h (got %h)",
                 name, redirect, redirect_pc, store_current, mode, epc, cause,
                 in_handler, state, double_fault, exp, act);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    branch_pc = 16'hB000;
    new_pc    = 16'h3000;
    cur_pc    = 16'h0000;
    idle_inputs();

    //   name            rst miss jmp eret exc   mask  mset   cur         expected
    add("reset",         1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("idle",          0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("mset_01",       0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("exc2_sample",   0, 0, 0, 0, 4'h4, 4'h0, 2'b00, 16'h0123, pk(0, 16'h0000, 0, 2'b00, 16'h0000, 2'd0, S_R, 0));
    add("exc2_service",  0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0123, pk(1, 16'h0200, 1, 2'b10, 16'h0000, 2'd0, S_R, 0));
    add("in_handler2",   0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0123, 2'd2, S_H, 0));
    add("eret2",         0, 0, 0, 1, 4'h0, 4'h0, 2'b00, 16'h0000, pk(1, 16'h0123, 0, 2'b00, 16'h0123, 2'd2, S_H, 0));
    add("after_eret2",   0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0123, 2'd2, S_R, 0));
    add("exc6_sample",   0, 0, 0, 0, 4'h6, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0123, 2'd2, S_R, 0));
    add("exc6_service",  0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0456, pk(1, 16'h0100, 1, 2'b10, 16'h0123, 2'd2, S_R, 0));
    add("eret1",         0, 0, 0, 1, 4'h0, 4'h0, 2'b00, 16'h0000, pk(1, 16'h0456, 0, 2'b10, 16'h0456, 2'd1, S_H, 0));
    add("exc6b_sample",  0, 0, 0, 0, 4'h6, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("miss_preempt",  0, 1, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0789, pk(1, 16'hB000, 0, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("after_miss",    0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("mask_all",      0, 0, 0, 0, 4'hF, 4'hF, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("jump_alone",    0, 0, 1, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(1, 16'h3000, 0, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("mask_low",      0, 0, 0, 0, 4'h3, 4'h1, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("exc1_over_jmp", 0, 0, 1, 0, 4'h0, 4'h0, 2'b00, 16'h0AAA, pk(1, 16'h0100, 1, 2'b10, 16'h0456, 2'd1, S_R, 0));
    add("h_exc0_sample", 0, 0, 0, 0, 4'h1, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0AAA, 2'd1, S_H, 0));
    add("double_fault",  0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0BBB, pk(1, 16'hFF00, 1, 2'b10, 16'h0AAA, 2'd1, S_H, 0));
    add("df_eret_ign",   0, 0, 0, 1, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b10, 16'h0AAA, 2'd1, S_D, 1));
    add("df_jump",       0, 0, 1, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(1, 16'h3000, 0, 2'b10, 16'h0AAA, 2'd1, S_D, 1));
    add("df_rst",        1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("post_rst",      0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("exc3_sample",   0, 0, 0, 0, 4'h8, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("exc3_service",  0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0CCC, pk(1, 16'h0300, 1, 2'b11, 16'h0000, 2'd0, S_R, 0));
    add("exc_with_eret", 0, 0, 0, 1, 4'h1, 4'h0, 2'b00, 16'h0000, pk(1, 16'h0CCC, 0, 2'b11, 16'h0CCC, 2'd3, S_H, 0));
    add("exc0_from_run", 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0DDD, pk(1, 16'h0000, 1, 2'b11, 16'h0CCC, 2'd3, S_R, 0));
    add("mset_11",       0, 0, 0, 0, 4'h0, 4'h0, 2'b11, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0DDD, 2'd0, S_H, 0));
    add("mset_01_h",     0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 16'h0000, pk(0, 16'h0000, 0, 2'b01, 16'h0DDD, 2'd0, S_H, 0));
    add("eret0_restore", 0, 0, 0, 1, 4'h0, 4'h0, 2'b00, 16'h0000, pk(1, 16'h0DDD, 0, 2'b00, 16'h0DDD, 2'd0, S_H, 0));
    add("restored_mode", 0, 0, 0, 0, 4'h0, 4'h0, 2'b10, 16'h0000, pk(0, 16'h0000, 0, 2'b11, 16'h0DDD, 2'd0, S_R, 0));
    add("mset_10",       0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 16'h0000, pk(0, 16'h0000, 0, 2'b01, 16'h0DDD, 2'd0, S_R, 0));

    // Table: drive after the rising edge, compare at the falling edge.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      check(vecs[i].name);
    end

    // Hand sequence: enter a handler, then assert reset mid-cycle.
    @(posedge clk);
    #1;
    idle_inputs();
    exc_in = 4'b0010;
    cur_pc = 16'h0EEE;
    @(posedge clk);
    #1;
    exc_in = 4'h0;
    exp_q.push_back(pk(1, 16'h0100, 1, 2'b11, 16'h0DDD, 2'd0, S_R, 0));
    @(negedge clk);
    check("seq_service");
    @(posedge clk);
    #1;
    exp_q.push_back(pk(0, 16'h0000, 0, 2'b11, 16'h0EEE, 2'd1, S_H, 0));
    @(negedge clk);
    check("seq_in_handler");
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(pk(0, 16'h0000, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    check("seq_async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    jump = 1'b1;
    new_pc = 16'h0000 + 16'($urandom_range(1, 16'hFFFE));
    exp_q.push_back(pk(1, new_pc, 0, 2'b11, 16'h0000, 2'd0, S_R, 0));
    @(negedge clk);
    check("seq_jump_after_rst");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL leftover: %0d expectations unconsumed, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
